// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for clock_ctrl: FSM states, rate-select
// width and the debounce counter sizing helper.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int RATE_SEL_W = 2;

    // Counter width able to represent 0..cycles.
    function automatic int db_cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/clock_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stable-level debouncer and
// a registered one-cycle pulse on each debounced 0->1 transition.
module debounce
    import clock_ctrl_pkg::*;
#(
    parameter int CYCLES = 200_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CNT_W = db_cnt_w(CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             dout_q, dout_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The level only flips after CYCLES consecutive disagreeing samples;
    // any agreeing sample in between restarts the count.
    always_comb begin
        dout_d = dout_q;
        cnt_d  = '0;
        if (sync2_q != dout_q) begin
            if (cnt_q == CNT_LAST) begin
                dout_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = dout_d & ~dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;

endmodule

// File: rtl/clock_ctrl.sv
// Lock-qualified reset sequencing and CPU clock-enable generation
// (free-run divider, debounced single-step, halt) for the SAP-2 core.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int DIV0            = 20_000_000,
    parameter int DIV1            = 2_000_000,
    parameter int DIV2            = 20_000,
    parameter int DIV3            = 20,
    parameter int DIV_W           = 25,
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int RST_HOLD        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  run_mode,
    input  logic [RATE_SEL_W-1:0] rate_sel,
    input  logic                  step_btn,
    input  logic                  cpu_halt,
    output logic                  cpu_ce,
    output logic                  cpu_rst_n,
    output logic                  ready
);

    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

    state_t                  state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [DIV_W-1:0]        div_last;
    logic                    ce_q, ce_d;
    logic                    rst_q, rst_d;
    logic                    halted_q, halted_d;
    logic [RATE_SEL_W-1:0]   rate_q;
    logic                    mode_q;
    logic                    lock_meta_q, locked_s_q;
    logic                    step_level, step_rise;
    logic                    switch_now;
    logic                    ce_allowed;

    debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (step_btn),
        .dout  (step_level),
        .rise  (step_rise)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        div_d      = '0;
        ce_d       = 1'b0;
        halted_d   = halted_q;
        div_last   = DIV_W'(DIV3 - 1);
        switch_now = (rate_sel != rate_q) || (run_mode != mode_q);

        case (rate_sel)
            2'd0:    div_last = DIV_W'(DIV0 - 1);
            2'd1:    div_last = DIV_W'(DIV1 - 1);
            2'd2:    div_last = DIV_W'(DIV2 - 1);
            default: div_last = DIV_W'(DIV3 - 1);
        endcase

        case (state_q)
            WAIT_LOCK: begin
                hold_d = '0;
                if (locked_s_q) state_d = HOLD;
            end
            HOLD: begin
                if (!locked_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!locked_s_q) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase

        // Halt only latches on a real CPU cycle and is forgotten whenever
        // the core is pushed back into reset.
        if (state_d != RUN) begin
            halted_d = 1'b0;
        end else if (ce_q && cpu_halt) begin
            halted_d = 1'b1;
        end

        // A rate or mode change spends one cycle with the divider at 0 and
        // no enable, so the new period always starts from a clean count.
        ce_allowed = (state_q == RUN) && (state_d == RUN) && !halted_d && !switch_now;
        if (ce_allowed) begin
            if (run_mode) begin
                div_d = (div_q == div_last) ? '0 : div_q + DIV_W'(1);
                ce_d  = (div_d == div_last);
            end else begin
                ce_d  = step_rise & step_level;
            end
        end

        rst_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_LOCK;
            hold_q      <= '0;
            div_q       <= '0;
            ce_q        <= 1'b0;
            rst_q       <= 1'b0;
            halted_q    <= 1'b0;
            rate_q      <= '0;
            mode_q      <= 1'b0;
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            div_q       <= div_d;
            ce_q        <= ce_d;
            rst_q       <= rst_d;
            halted_q    <= halted_d;
            rate_q      <= rate_sel;
            mode_q      <= run_mode;
            lock_meta_q <= pll_locked;
            locked_s_q  <= lock_meta_q;
        end
    end

    assign cpu_ce    = ce_q;
    assign cpu_rst_n = rst_q;
    assign ready     = (state_q == RUN);

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with DIV 8/4/2/1, DEBOUNCE_CYCLES=5,
// RST_HOLD=4; expected cycle positions are hand-derived per scenario.
module tb_clock_ctrl;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       run_mode;
    logic [1:0] rate_sel;
    logic       step_btn;
    logic       cpu_halt;
    logic       cpu_ce;
    logic       cpu_rst_n;
    logic       ready;

    int total;
    int bad;

    clock_ctrl #(
        .DIV0            (8),
        .DIV1            (4),
        .DIV2            (2),
        .DIV3            (1),
        .DIV_W           (4),
        .DEBOUNCE_CYCLES (5),
        .RST_HOLD        (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .run_mode   (run_mode),
        .rate_sel   (rate_sel),
        .step_btn   (step_btn),
        .cpu_halt   (cpu_halt),
        .cpu_ce     (cpu_ce),
        .cpu_rst_n  (cpu_rst_n),
        .ready      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_locked = 1'b0; run_mode = 1'b0; rate_sel = 2'd0;
        step_btn = 1'b0; cpu_halt = 1'b0;
        #1;
        total++;
        if (cpu_ce !== 1'b0) begin bad++; $display("FAIL reset_ce got=%b want=0", cpu_ce); end
        total++;
        if (cpu_rst_n !== 1'b0) begin bad++; $display("FAIL reset_cpu_rst_n got=%b want=0", cpu_rst_n); end
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready); end
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_lock_seq();
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({cpu_ce, cpu_rst_n, ready} !== 3'b000) begin
                bad++; $display("FAIL prelock k=%0d ce/rst_n/ready got=%b want=000", k, {cpu_ce, cpu_rst_n, ready});
            end
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (cpu_rst_n !== (i >= 6)) begin
                bad++; $display("FAIL lock_seq_rst_n i=%0d got=%b want=%b", i, cpu_rst_n, (i >= 6));
            end
            total++;
            if (ready !== (i >= 6)) begin
                bad++; $display("FAIL lock_seq_ready i=%0d got=%b want=%b", i, ready, (i >= 6));
            end
            total++;
            if (cpu_ce !== 1'b0) begin
                bad++; $display("FAIL lock_seq_ce i=%0d got=%b want=0", i, cpu_ce);
            end
        end
    endtask

    task automatic test_free_run();
        run_mode = 1'b1; rate_sel = 2'd0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            total++;
            if (cpu_ce !== (k % 8 == 0)) begin
                bad++; $display("FAIL free_run_div8 k=%0d got=%b want=%b", k, cpu_ce, (k % 8 == 0));
            end
        end
        rate_sel = 2'd1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            total++;
            if (cpu_ce !== (k % 4 == 0)) begin
                bad++; $display("FAIL free_run_div4 k=%0d got=%b want=%b", k, cpu_ce, (k % 4 == 0));
            end
        end
        rate_sel = 2'd3;
        for (int k = 1; k <= 6; k++) begin
            tick();
            total++;
            if (cpu_ce !== (k >= 2)) begin
                bad++; $display("FAIL free_run_div1 k=%0d got=%b want=%b", k, cpu_ce, (k >= 2));
            end
        end
    endtask

    task automatic test_single_step();
        run_mode = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (cpu_ce !== 1'b0) begin bad++; $display("FAIL mode_switch_ce k=%0d got=%b want=0", k, cpu_ce); end
        end
        // Bounce 1-0-1-0 at 2-cycle spacing, then hold high from i=8.
        for (int i = 0; i < 28; i++) begin
            step_btn = (i >= 8) ? 1'b1 : (((i / 2) % 2) == 0);
            tick();
            total++;
            if (cpu_ce !== (i == 15)) begin
                bad++; $display("FAIL step_bounce i=%0d got=%b want=%b", i, cpu_ce, (i == 15));
            end
        end
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (cpu_ce !== 1'b0) begin bad++; $display("FAIL step_release i=%0d got=%b want=0", i, cpu_ce); end
        end
        step_btn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            total++;
            if (cpu_ce !== (i == 7)) begin
                bad++; $display("FAIL step_second i=%0d got=%b want=%b", i, cpu_ce, (i == 7));
            end
        end
    endtask

    task automatic test_halt();
        step_btn = 1'b0; run_mode = 1'b1; rate_sel = 2'd2;
        for (int k = 1; k <= 5; k++) begin
            // Halt asserted in a no-ce cycle (ignored) and then in a ce cycle.
            cpu_halt = (k == 4) || (k == 5);
            tick();
            total++;
            if (cpu_ce !== (k == 2 || k == 4)) begin
                bad++; $display("FAIL halt_entry k=%0d got=%b want=%b", k, cpu_ce, (k == 2 || k == 4));
            end
        end
        cpu_halt = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if (cpu_ce !== 1'b0) begin bad++; $display("FAIL halted_free k=%0d got=%b want=0", k, cpu_ce); end
        end
        run_mode = 1'b0; step_btn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            total++;
            if (cpu_ce !== 1'b0) begin bad++; $display("FAIL halted_step k=%0d got=%b want=0", k, cpu_ce); end
        end
        step_btn = 1'b0;
        repeat (10) tick();
        pll_locked = 1'b0; run_mode = 1'b1; rate_sel = 2'd2;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (ready !== (i < 2)) begin bad++; $display("FAIL halt_unlock_ready i=%0d got=%b want=%b", i, ready, (i < 2)); end
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            total++;
            if (cpu_rst_n !== (i >= 6)) begin
                bad++; $display("FAIL halt_relock_rst_n i=%0d got=%b want=%b", i, cpu_rst_n, (i >= 6));
            end
            total++;
            if (cpu_ce !== ((i >= 7) && ((i - 7) % 2 == 0))) begin
                bad++; $display("FAIL halt_resume_ce i=%0d got=%b want=%b", i, cpu_ce, ((i >= 7) && ((i - 7) % 2 == 0)));
            end
        end
    endtask

    task automatic test_lock_loss();
        rate_sel = 2'd1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            total++;
            if (cpu_ce !== (k % 4 == 0)) begin
                bad++; $display("FAIL loss_prerun k=%0d got=%b want=%b", k, cpu_ce, (k % 4 == 0));
            end
        end
        pll_locked = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (cpu_rst_n !== (i < 2)) begin
                bad++; $display("FAIL loss_rst_n i=%0d got=%b want=%b", i, cpu_rst_n, (i < 2));
            end
            total++;
            if (cpu_ce !== 1'b0) begin bad++; $display("FAIL loss_ce i=%0d got=%b want=0", i, cpu_ce); end
        end
        pll_locked = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (ready !== (i >= 6)) begin
                bad++; $display("FAIL loss_relock_ready i=%0d got=%b want=%b", i, ready, (i >= 6));
            end
            total++;
            if (cpu_ce !== 1'b0) begin bad++; $display("FAIL loss_relock_ce i=%0d got=%b want=0", i, cpu_ce); end
        end
    endtask

    task automatic test_async_reset();
        rate_sel = 2'd3;
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++;
            if (cpu_ce !== (k >= 2)) begin
                bad++; $display("FAIL areset_pre k=%0d got=%b want=%b", k, cpu_ce, (k >= 2));
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({cpu_ce, cpu_rst_n, ready} !== 3'b000) begin
            bad++; $display("FAIL areset_now ce/rst_n/ready got=%b want=000", {cpu_ce, cpu_rst_n, ready});
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (cpu_rst_n !== (i >= 6)) begin
                bad++; $display("FAIL areset_reseq i=%0d got=%b want=%b", i, cpu_rst_n, (i >= 6));
            end
            total++;
            if (cpu_ce !== (i >= 7)) begin
                bad++; $display("FAIL areset_ce i=%0d got=%b want=%b", i, cpu_ce, (i >= 7));
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_lock_seq();
        test_free_run();
        test_single_step();
        test_halt();
        test_lock_loss();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Clock-management successor to the bare PLL wrapper. Sits between the PLL output and the SAP-2 core.
- Qualifies reset with PLL lock.
- Produces a single-cycle CPU clock enable, `cpu_ce`, in one of three modes:
  - free-run at one of four parametrised divide ratios;
  - single-step from a debounced push-button;
  - halted.
- The core stays on one clock domain (`clk` = PLL output) and is gated only by `cpu_ce`.

Parameters:
- DIV0, default 20_000_000, divide ratio for rate_sel=0 (1 Hz at 20 MHz).
- DIV1, default 2_000_000, divide ratio for rate_sel=1 (10 Hz).
- DIV2, default 20_000, divide ratio for rate_sel=2 (1 kHz).
- DIV3, default 20, divide ratio for rate_sel=3 (1 MHz).
- DIV_W, default 25, divider counter width; must satisfy 2^DIV_W > max(DIVn).
- DEBOUNCE_CYCLES, default 200_000, stable-level cycles required on step_btn (10 ms).
- RST_HOLD, default 16, cycles cpu_rst_n stays low after lock is qualified.

Ports:
- clk  in  1  system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL LOCK; asynchronous, synchronised internally
- run_mode  in  1  1 = free-run, 0 = single-step; synchronous to clk
- rate_sel  in  2  free-run rate select; synchronous
- step_btn  in  1  raw push-button, active-high, asynchronous, bouncy
- cpu_halt  in  1  HLT from core; synchronous
- cpu_ce  out  1  one-cycle clock enable to the core
- cpu_rst_n  out  1  synchronous active-low reset to the core
- ready  out  1  high while state is RUN

Behaviour:
- **Reset (rst_n low, asynchronous):**
  - state=WAIT_LOCK
  - cpu_ce=0, cpu_rst_n=0, ready=0
  - divider=0, hold counter=0, halted flag=0
  - synchroniser and debounce flops=0
- **Synchronisation:** pll_locked and step_btn each pass through a 2-flop synchroniser. Decisions use the synchronised values, which adds 2 cycles of latency.
- **State machine:**
  - WAIT_LOCK: if locked_s=1, go to HOLD; hold counter=0.
  - HOLD: increment hold counter. When the counter reaches RST_HOLD-1, go to RUN.
  - RUN: normal operation.
  - From HOLD or RUN, locked_s=0 returns to WAIT_LOCK on the next edge.
  - cpu_rst_n is registered: 1 only in RUN. It therefore rises exactly RST_HOLD cycles after HOLD is entered.
  - Lock loss mid-run drives cpu_rst_n=0 and cpu_ce=0 on the next cycle, and clears the halted flag.
- **Halt:**
  - cpu_halt=1 while cpu_ce=1 sets the halted flag.
  - halted=1 suppresses all cpu_ce, in both modes, until reset or lock loss.
  - cpu_halt is ignored when cpu_ce=0.
- **Free-run (RUN, run_mode=1, not halted):**
  - divider counts 0..DIVsel-1.
  - cpu_ce=1 on the cycle the divider equals DIVsel-1; divider then wraps to 0.
  - Period is exactly DIVsel cycles.
  - A rate_sel change resets the divider to 0 on the next cycle, with no ce that cycle. A new period therefore starts cleanly and no short or long glitch pulse is emitted.
  - DIVn=1 gives cpu_ce continuously high.
- **Single-step (RUN, run_mode=0, not halted):**
  - The debouncer's output level changes only after step_s has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A 0→1 transition of the debounced level produces exactly one cpu_ce pulse on the next cycle.
  - Holding the button gives no further pulses.
  - The divider is held at 0.
- **Mode switch:**
  - Switching run_mode resets the divider.
  - A step edge that is pending while in free-run is discarded.
  - No ce is emitted on the switch cycle.
- **Outside RUN:** cpu_ce=0 always. Button edges are discarded and are not queued.

Decomposition:
- clock_ctrl_pkg:
  - state enum {WAIT_LOCK, HOLD, RUN}
  - rate_sel width constant
  - debounce counter width derived via $clog2(DEBOUNCE_CYCLES+1)
- One sub-module, `debounce`:
  - parameter CYCLES
  - ports clk, rst_n, din (raw), dout (stable level), rise (1-cycle pulse)
  - contains the 2-flop synchroniser

Test Plan (DIV0..3 = 8,4,2,1, DEBOUNCE_CYCLES=5, RST_HOLD=4):
- **Lock sequencing:** rst_n released, pll_locked raised at cycle 10 → cpu_rst_n=0 until 2 sync + 4 hold cycles, then 1 with ready=1; cpu_ce=0 throughout.
- **Free-run rates:** run_mode=1, rate_sel=0 → cpu_ce every 8 cycles. Switch to rate_sel=1 → next ce exactly 4 cycles after the divider reset, then every 4. rate_sel=3 → ce continuously 1.
- **Single-step debounce:** run_mode=0, step_btn bounces 1-0-1-0 at 2-cycle intervals then holds 1 for 20 cycles → exactly one cpu_ce pulse, 2+5+1 cycles after the final rise. Release and press again → exactly one more pulse.
- **Halt:** free-run at rate 2, assert cpu_halt during a ce cycle → no further cpu_ce. Pressing step_btn in step mode also gives no pulse. Dropping pll_locked and raising it again re-sequences, and ce resumes.
- **Lock loss mid-run:** at rate 1, drop pll_locked → cpu_rst_n=0 and cpu_ce=0 within 3 cycles. Relock → full HOLD of 4 cycles before ready.
- **Async reset mid-operation:** pulse rst_n low between clock edges → all outputs 0 immediately, before the next edge.
